// File: rtl/alu_uadd_seq.sv
// rtl/alu_uadd_seq.sv - slice-serial unsigned adder with valid/ready handshakes
//
// alu_uadd     : combinational SIZE-bit unsigned adder, no carry-in.
// alu_uadd_seq : adds two SIZE*WORDS-bit operands one SIZE-bit slice per cycle,
//                least significant slice first, carry kept in a register.
//
// alu_uadd_seq ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_valid / o_ready  operand handshake (accepted only in IDLE)
//   i_s1, i_s2         operands, captured on acceptance
//   o_valid / i_ready  result handshake (held in DONE until i_ready)
//   o_result, o_carry  sum modulo 2^(SIZE*WORDS) and carry out of the MSB
//   o_overflow         signed overflow of the captured operands, present only
//                      when ALU_UADD_SEQ_OVF_EN is defined

module alu_uadd #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    output logic [SIZE-1:0] o_sum,
    output logic            o_carry
);
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module alu_uadd_seq #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE*WORDS-1:0] i_s1,
    input  logic [SIZE*WORDS-1:0] i_s2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE*WORDS-1:0] o_result,
`ifdef ALU_UADD_SEQ_OVF_EN
    output logic                  o_overflow,
`endif
    output logic                  o_carry
);
    localparam int W  = SIZE * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    s1_q, s1_d;
    logic [W-1:0]    s2_q, s2_d;
    logic [W-1:0]    result_q, result_d;
`ifdef ALU_UADD_SEQ_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [SIZE-1:0] slice_a, slice_b;
    logic [SIZE-1:0] sum1, sum2;
    logic            c1, c2;
    logic            last;

    assign last = (k_q == KW'(WORDS - 1));

    // Slice k of each captured operand.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k_q == KW'(i)) begin
                slice_a = s1_q[i*SIZE +: SIZE];
                slice_b = s2_q[i*SIZE +: SIZE];
            end
        end
    end

    // The slice adder has no carry-in, so the registered carry is added in a
    // second pass. Both passes can never carry together, so OR-ing them gives
    // the true carry out of this slice.
    alu_uadd #(.SIZE(SIZE)) u_pass1 (
        .i_a     (slice_a),
        .i_b     (slice_b),
        .o_sum   (sum1),
        .o_carry (c1)
    );

    alu_uadd #(.SIZE(SIZE)) u_pass2 (
        .i_a     (sum1),
        .i_b     (SIZE'(carry_q)),
        .o_sum   (sum2),
        .o_carry (c2)
    );

    // State register and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            result_q <= '0;
`ifdef ALU_UADD_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
`ifdef ALU_UADD_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = ST_RUN;
            ST_RUN:  if (last)    state_d = ST_DONE;
            ST_DONE: if (i_ready) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Datapath next values. Result and carry are only touched in RUN, so
    // they hold through DONE and IDLE until the next operation starts.
    always_comb begin
        k_d      = k_q;
        carry_d  = carry_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
`ifdef ALU_UADD_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (state_q == ST_IDLE && i_valid) begin
            s1_d    = i_s1;
            s2_d    = i_s2;
            carry_d = 1'b0;
            k_d     = '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (k_q == KW'(i)) begin
                    result_d[i*SIZE +: SIZE] = sum2;
                end
            end
            carry_d = c1 | c2;
            k_d     = last ? '0 : k_q + KW'(1);
`ifdef ALU_UADD_SEQ_OVF_EN
            if (last) begin
                ovf_d = (s1_q[W-1] == s2_q[W-1]) && (result_d[W-1] != s1_q[W-1]);
            end
`endif
        end
    end

    // Outputs.
    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_valid = (state_q == ST_DONE);
    end

    assign o_result = result_q;
    assign o_carry  = carry_q;
`ifdef ALU_UADD_SEQ_OVF_EN
    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_uadd_seq.sv
// tb/tb_alu_uadd_seq.sv - directed-vector bench for alu_uadd_seq (SIZE=8, WORDS=4)

module tb_alu_uadd_seq;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_s1;
    logic [31:0] i_s2;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_carry;
`ifdef ALU_UADD_SEQ_OVF_EN
    logic        o_overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_uadd_seq #(.SIZE(8), .WORDS(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_s1       (i_s1),
        .i_s2       (i_s2),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
`ifdef ALU_UADD_SEQ_OVF_EN
        .o_overflow (o_overflow),
`endif
        .o_carry    (o_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction. mutate: scramble the operand inputs during RUN.
    // hold: cycles spent in DONE with i_ready low (and junk on i_valid/i_s1).
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_c,
                         input bit mutate, input int hold);
        int n;
        @(negedge clk);
        check_eq({tag, ".rdy_idle"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_s1    = a;
        i_s2    = b;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        check_eq({tag, ".rdy_run"}, 32'(o_ready), 32'd0);
        if (mutate) begin
            i_s1 = ~a;
            i_s2 = ~b;
        end
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".latency"}, 32'(n), 32'd4);
        check_eq({tag, ".result"}, o_result, exp_r);
        check_eq({tag, ".carry"}, 32'(o_carry), 32'(exp_c));
        check_eq({tag, ".rdy_done"}, 32'(o_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            i_s1    = 32'hDEAD_BEEF;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, ".hold_result"}, o_result, exp_r);
            check_eq({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            check_eq({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        check_eq({tag, ".valid_after"}, 32'(o_valid), 32'd0);
        check_eq({tag, ".rdy_after"}, 32'(o_ready), 32'd1);
        check_eq({tag, ".retain"}, o_result, exp_r);
        check_eq({tag, ".retain_c"}, 32'(o_carry), 32'(exp_c));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_s1    = '0;
        i_s2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.ready", 32'(o_ready), 32'd1);
        check_eq("rst.valid", 32'(o_valid), 32'd0);
        check_eq("rst.result", o_result, 32'd0);
        check_eq("rst.carry", 32'(o_carry), 32'd0);
        rst_n = 1'b1;

        do_op("slice_carry", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 0);
        do_op("wrap",        32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("backpress",   32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 3);
        do_op("alt_bits",    32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op("max_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        do_op("msb_msb",     32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("op_change",   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b1, 0);

        // Reset while slice k=2 is pending.
        @(negedge clk);
        i_valid = 1'b1;
        i_s1    = 32'h0101_0101;
        i_s2    = 32'h0101_0101;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst.valid", 32'(o_valid), 32'd0);
        check_eq("midrst.result", o_result, 32'd0);
        check_eq("midrst.ready", 32'(o_ready), 32'd1);
        check_eq("midrst.carry", 32'(o_carry), 32'd0);
        rst_n = 1'b1;
        do_op("after_rst", 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 0);

`ifdef ALU_UADD_SEQ_OVF_EN
        do_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 0);
        check_eq("ovf.flag", 32'(o_overflow), 32'd1);
        do_op("no_ovf", 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 0);
        check_eq("no_ovf.flag", 32'(o_overflow), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_uadd_seq.md
ALU_UADD_SEQ -- requirements
Module: alu_uadd_seq

Interface
REQ-001 SIZE, default 8: width of one adder slice in bits.
REQ-002 WORDS, default 4, minimum 1: number of slices per operand; operand width is SIZE*WORDS.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  requester presents an operand pair.
REQ-006 o_ready  output  1  block accepts an operand pair this cycle.
REQ-007 i_s1  input  SIZE*WORDS  first operand, unsigned.
REQ-008 i_s2  input  SIZE*WORDS  second operand, unsigned.
REQ-009 o_valid  output  1  result available.
REQ-010 i_ready  input  1  consumer takes the result this cycle.
REQ-011 o_result  output  SIZE*WORDS  (i_s1+i_s2) mod 2^(SIZE*WORDS).
REQ-012 o_carry  output  1  carry out of the most significant bit.

Function
REQ-013 The block SHALL add one SIZE-bit slice per cycle using internal alu_uadd instances, least significant slice first.
REQ-014 Carry-in: alu_uadd has none, so the block SHALL add the registered carry in a second alu_uadd pass (slice sum + zero-extended carry); next carry = OR of both pass carries.
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE: o_ready=1, o_valid=0; i_valid=1 SHALL capture i_s1/i_s2 into internal registers, clear carry and slice index k, and go to RUN.
REQ-017 After capture, later changes on i_s1/i_s2 SHALL NOT affect the result.
REQ-018 RUN: o_ready=0, o_valid=0; each cycle writes result slice k, updates the carry register and increments k.
REQ-019 RUN -> DONE on the cycle that k=WORDS-1 is processed; with WORDS=1 RUN lasts exactly one cycle.
REQ-020 Latency: o_valid SHALL rise exactly WORDS cycles after the accepting edge.
REQ-021 DONE: o_valid=1, o_ready=0; o_result and o_carry SHALL hold stable until i_ready=1.
REQ-022 DONE with i_ready=1 -> IDLE; no new operands are accepted in that same cycle, so minimum issue interval is WORDS+2 cycles.
REQ-023 i_ready is ignored outside DONE; i_valid is ignored outside IDLE.
REQ-024 o_result and o_carry SHALL retain the last result in IDLE until the next acceptance.

Reset
REQ-025 i_rst_n=0 at a rising edge SHALL force IDLE and clear k, carry, o_result, o_carry, o_valid; o_ready=1 from the first cycle after reset.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no result issued.

Configuration
REQ-027 Macro ALU_UADD_SEQ_OVF_EN: when defined, output o_overflow (1 bit) SHALL exist; value = (s1 MSB == s2 MSB) && (result MSB != s1 MSB) for the captured operands; valid with o_valid, held like o_result, reset to 0.
REQ-028 Without ALU_UADD_SEQ_OVF_EN, the o_overflow port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (SIZE=8, WORDS=4)
REQ-029 Carry across slices: 0x000000FF + 0x00000001 -> o_result=0x00000100, o_carry=0, o_valid rises 4 cycles after acceptance.
REQ-030 Full wrap: 0xFFFFFFFF + 0x00000001 -> o_result=0x00000000, o_carry=1.
REQ-031 Backpressure: 0x12345678 + 0x11111111 with i_ready held 0 for 3 cycles in DONE -> o_result=0x23456789 stable, o_valid=1, o_ready=0 throughout; IDLE one cycle after i_ready=1.
REQ-032 Reset mid-run: assert i_rst_n=0 at k=2 -> next cycle o_valid=0, o_result=0, o_ready=1; a following 0x00000002+0x00000003 returns 0x00000005.
REQ-033 Operand change: alter i_s1 during RUN -> result reflects captured value only.
REQ-034 With ALU_UADD_SEQ_OVF_EN: 0x7FFFFFFF + 0x00000001 -> o_result=0x80000000, o_overflow=1, o_carry=0.
